proc_core_param: RTL and testbench

- Second-generation multi-cycle 8-bit-style processor core, generalised in data width, address width, register count and ALU operations.
- Adds condition flags, conditional jumps, a memory wait-state handshake and a register-write trace bus.
- Instantiated in the SoC between the instruction memory and the system bus.
- Replaces the fixed-timing fetch with ready-qualified fetches.

---
 rtl/proc_pkg.sv | 81 ++++++++
 rtl/proc_alu.sv | 69 ++++++
 rtl/proc_core_param.sv | 156 +++++++++++++++
 tb/tb_proc_core_param.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the parameterised multi-cycle core.
// Macro PROC_HALT_EN enables the 7F halt opcode in the core.
package proc_pkg;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_LD,
    OP_ADD,
    OP_ADC,
    OP_SUB,
    OP_SBC,
    OP_OR,
    OP_AND,
    OP_XOR,
    OP_CP,
    OP_INC
  } alu_op_t;

  localparam logic [3:0] LN_RR  = 4'h2;
  localparam logic [3:0] LN_MOV = 4'h8;
  localparam logic [3:0] LN_LDI = 4'hC;
  localparam logic [3:0] LN_JP  = 4'hD;
  localparam logic [3:0] LN_INC = 4'hE;

  localparam logic [3:0] CC_NEV = 4'h0;
  localparam logic [3:0] CC_Z   = 4'h6;
  localparam logic [3:0] CC_C   = 4'h7;
  localparam logic [3:0] CC_ALW = 4'h8;
  localparam logic [3:0] CC_NZ  = 4'hE;
  localparam logic [3:0] CC_NC  = 4'hF;

  function automatic logic [1:0] insn_size(
    input logic [7:0] b0
  );
    if (b0[3:0] == LN_INC || b0 == 8'hFF ||
        b0 == 8'h7F)
      return 2'd1;
    if (b0[3:0] == LN_JP)
      return 2'd3;
    return 2'd2;
  endfunction

  function automatic logic cc_true(
    input logic [3:0] cc,
    input logic       c,
    input logic       z
  );
    case (cc)
      CC_ALW:  return 1'b1;
      CC_Z:    return z;
      CC_NZ:   return !z;
      CC_C:    return c;
      CC_NC:   return !c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t rr_op(
    input logic [3:0] h
  );
    case (h)
      4'h0:    return OP_ADD;
      4'h1:    return OP_ADC;
      4'h2:    return OP_SUB;
      4'h3:    return OP_SBC;
      4'h4:    return OP_OR;
      4'h5:    return OP_AND;
      4'hA:    return OP_CP;
      4'hB:    return OP_XOR;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: a, b, op, carry/zero in -> result, C, Z, we.
// Flags not touched by an op pass through from ci/zi.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  input  logic              ci,
  input  logic              zi,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z,
  output logic              we
);

  localparam logic [DATA_W:0] ONE = 1;

  logic [DATA_W:0] ax, bx, cx, s;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};
  assign cx = {{DATA_W{1'b0}}, ci};

  always_comb begin
    s  = '0;
    y  = b;
    c  = ci;
    z  = zi;
    we = 1'b0;
    unique case (op)
      OP_LD: we = 1'b1;
      OP_INC: begin
        s  = ax + ONE;
        y  = s[DATA_W-1:0];
        z  = ~|y;
        we = 1'b1;
      end
      OP_ADD, OP_ADC,
      OP_SUB, OP_SBC, OP_CP: begin
        unique case (op)
          OP_ADD:  s = ax + bx;
          OP_ADC:  s = ax + bx + cx;
          OP_SBC:  s = ax - bx - cx;
          default: s = ax - bx;
        endcase
        // bit DATA_W is carry for add, borrow for sub
        y  = s[DATA_W-1:0];
        c  = s[DATA_W];
        z  = ~|y;
        we = (op != OP_CP);
      end
      OP_OR, OP_AND, OP_XOR: begin
        unique case (op)
          OP_OR:   y = a | b;
          OP_AND:  y = a & b;
          default: y = a ^ b;
        endcase
        c  = 1'b0;
        z  = ~|y;
        we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/proc_core_param.sv
// Multi-cycle core: ready-qualified byte fetch, decode, 1-cycle exec.
// Ports: mem fetch (memAddr/memStrobe/memDataRead/memReady), trace
// (regWrEn/regWrAddr/regWrData), flags {C,Z}, halted (PROC_HALT_EN).
module proc_core_param
  import proc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memStrobe,
  input  logic [DATA_W-1:0] memDataRead,
  input  logic              memReady,
  output logic              regWrEn,
  output logic [3:0]        regWrAddr,
  output logic [DATA_W-1:0] regWrData,
  output logic [1:0]        flags,
  output logic              halted
);

  localparam int RW = $clog2(NUM_REGS);

  state_t            state, nxt;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        idx;
  logic [DATA_W-1:0] b0, b1, b2;
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic              cf, zf;

  logic [3:0]        hi, lo;
  logic [RW-1:0]     dst, src;
  alu_op_t           op;
  logic [DATA_W-1:0] opb, y;
  logic              c_n, z_n, we;
  logic [7:0]        first;
  logic [1:0]        size;
  logic              done, take, halt_hit;
  logic [15:0]       tgt;

  assign hi = b0[7:4];
  assign lo = b0[3:0];

  always_comb begin
    dst = hi[RW-1:0];
    src = b1[RW-1:0];
    op  = OP_NOP;
    opb = rf[src];
    unique case (1'b1)
      (lo == LN_LDI): begin
        op  = OP_LD;
        opb = b1;
      end
      (lo == LN_MOV): op = OP_LD;
      (lo == LN_INC): op = OP_INC;
      (lo == LN_RR): begin
        dst = b1[4+RW-1:4];
        op  = rr_op(hi);
      end
      default: ;
    endcase
  end

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (rf[dst]),
    .b  (opb),
    .op (op),
    .ci (cf),
    .zi (zf),
    .y  (y),
    .c  (c_n),
    .z  (z_n),
    .we (we)
  );

  // size must be known from the byte arriving right now
  assign first = (idx == 2'd0) ?
                 memDataRead[7:0] : b0[7:0];
  assign size  = insn_size(first);
  assign done  = ({1'b0, idx} + 3'd1) >=
                 {1'b0, size};
  assign tgt   = {b1[7:0], b2[7:0]};
  assign take  = (state == S_EXEC) &&
                 (lo == LN_JP) &&
                 cc_true(hi, cf, zf);

`ifdef PROC_HALT_EN
  assign halt_hit = (state == S_EXEC) &&
                    (b0[7:0] == 8'h7F);
  assign halted   = (state == S_HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: nxt = S_WAIT;
      S_WAIT:
        if (memReady)
          nxt = done ? S_EXEC : S_FETCH;
      S_EXEC:
        nxt = halt_hit ? S_HALT : S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
      pc    <= ADDR_W'(RESET_PC);
      idx   <= '0;
      b0    <= '0;
      b1    <= '0;
      b2    <= '0;
      cf    <= 1'b0;
      zf    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else begin
      state <= nxt;
      if (state == S_WAIT && memReady) begin
        pc  <= pc + ADDR_W'(1);
        idx <= idx + 2'd1;
        case (idx)
          2'd0:    b0 <= memDataRead;
          2'd1:    b1 <= memDataRead;
          default: b2 <= memDataRead;
        endcase
      end
      if (state == S_EXEC) begin
        idx <= '0;
        cf  <= c_n;
        zf  <= z_n;
        if (we)
          rf[dst] <= y;
        if (take)
          pc <= ADDR_W'(tgt);
      end
    end
  end

  // strobe is masked while reset is held
  assign memAddr   = pc;
  assign memStrobe = (state == S_FETCH) & reset_n;
  assign regWrEn   = (state == S_EXEC) & we;
  assign regWrAddr = 4'(dst);
  assign regWrData = y;
  assign flags     = {cf, zf};

endmodule

// File: tb/tb_proc_core_param.sv
// Bench for proc_core_param: instruction-level model vs DUT events.
// Random wait-state memory; optional PROC_HALT_EN scenario.
module tb_proc_core_param;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] memAddr;
  logic        memStrobe;
  logic [7:0]  memDataRead;
  logic        memReady;
  logic        regWrEn;
  logic [3:0]  regWrAddr;
  logic [7:0]  regWrData;
  logic [1:0]  flags;
  logic        halted;

  always #5 clk = ~clk;

  proc_core_param #(
    .DATA_W(8), .ADDR_W(16),
    .NUM_REGS(NR), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .memAddr(memAddr), .memStrobe(memStrobe),
    .memDataRead(memDataRead), .memReady(memReady),
    .regWrEn(regWrEn), .regWrAddr(regWrAddr),
    .regWrData(regWrData), .flags(flags),
    .halted(halted)
  );

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [1:0]  f;
    bit          first;
    int          gap;
  } obs_t;

  obs_t        obs[$];
  logic [7:0]  mem [65536];
  logic [7:0]  prog[$];
  logic [11:0] wr_log[$];
  logic [1:0]  flag_at[int];
  int          hits[int];
  int vec, errs;
  bit checking, stale;
  int wlo, whi;
  int cyc, prev_first, first_s, first_w;
  bit have_prev;

  logic [7:0]  mregs [NR];
  logic        mc, mz, mhalt;
  logic [15:0] mpc;
  int          prev_cost;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, required %h",
               nm, act, exp);
    end
  endtask

  // memory with wait states and garbage ready outside WAIT
  initial begin
    logic [15:0] ra;
    int cnt;
    bit pend;
    pend = 0;
    cnt = 0;
    ra = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 0;
        memReady = 1'($urandom);
        memDataRead = 8'($urandom);
      end else if (memStrobe) begin
        ra = memAddr;
        cnt = $urandom_range(whi, wlo);
        pend = 1;
        if (stale) begin
          memReady = 1'b1;
          memDataRead = 8'hA5;
          stale = 0;
        end else begin
          memReady = 1'($urandom);
          memDataRead = 8'($urandom);
        end
      end else if (pend) begin
        if (cnt == 0) begin
          memReady = 1'b1;
          memDataRead = mem[ra];
          pend = 0;
        end else begin
          cnt--;
          memReady = 1'b0;
          memDataRead = 8'($urandom);
        end
      end else begin
        memReady = 1'($urandom);
        memDataRead = 8'($urandom);
      end
    end
  end

  // compare process
  initial begin
    obs_t o;
    forever begin
      @(negedge clk);
      if (checking && reset_n) begin
        cyc++;
`ifndef PROC_HALT_EN
        chk("halted_low", {31'd0, halted}, 0);
`endif
        if (memStrobe) begin
          flag_at[int'(memAddr)] = flags;
          if (hits.exists(int'(memAddr)))
            hits[int'(memAddr)]++;
          else
            hits[int'(memAddr)] = 1;
          if (first_s < 0) first_s = cyc;
          if (obs.size() == 0 || obs[0].wr) begin
            vec++;
            errs++;
            $display("FAIL unexpected_strobe: got %h, required none",
                     memAddr);
          end else begin
            o = obs.pop_front();
            chk("fetch_addr", {16'd0, memAddr}, {16'd0, o.a});
            chk("flags", {30'd0, flags}, {30'd0, o.f});
            if (o.first) begin
              if (have_prev && wlo == whi)
                chk("insn_cycles", cyc - prev_first, o.gap);
              prev_first = cyc;
              have_prev = 1;
            end
          end
        end
        if (regWrEn) begin
          wr_log.push_back({regWrAddr, regWrData});
          if (first_w < 0) first_w = cyc;
          if (obs.size() == 0 || !obs[0].wr) begin
            vec++;
            errs++;
            $display("FAIL unexpected_write: got r%0d=%h, required none",
                     regWrAddr, regWrData);
          end else begin
            o = obs.pop_front();
            chk("wr_addr", {28'd0, regWrAddr}, {28'd0, o.a[3:0]});
            chk("wr_data", {24'd0, regWrData}, {24'd0, o.d});
          end
        end
      end
    end
  end

  task automatic mwrite(input int r, input int v);
    obs_t o;
    o.wr = 1;
    o.a = 16'(r % NR);
    o.d = 8'(v);
    o.f = 0;
    o.first = 0;
    o.gap = 0;
    mregs[r % NR] = 8'(v);
    obs.push_back(o);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 0;
    mc = 0;
    mz = 0;
    mhalt = 0;
    mpc = 0;
    prev_cost = 0;
    obs.delete();
  endtask

  task automatic model_step();
    obs_t o;
    logic [7:0] b [3];
    int sz, h, l, a, bb, r, ds;
    bit t;
    b[0] = mem[mpc];
    b[1] = 0;
    b[2] = 0;
    if (b[0][3:0] == 4'hE || b[0] == 8'hFF || b[0] == 8'h7F)
      sz = 1;
    else if (b[0][3:0] == 4'hD)
      sz = 3;
    else
      sz = 2;
    for (int i = 0; i < sz; i++) begin
      o.wr = 0;
      o.a = mpc;
      o.d = 0;
      o.f = {mc, mz};
      o.first = (i == 0);
      o.gap = prev_cost;
      obs.push_back(o);
      b[i] = mem[mpc];
      mpc = mpc + 16'd1;
    end
    prev_cost = sz * (2 + wlo) + 1;
    h = int'(b[0][7:4]);
    l = int'(b[0][3:0]);
    if (l == 12) begin
      mwrite(h, int'(b[1]));
    end else if (l == 8) begin
      mwrite(h, int'(mregs[int'(b[1][3:0]) % NR]));
    end else if (l == 14) begin
      r = (int'(mregs[h % NR]) + 1) & 255;
      mz = (r == 0);
      mwrite(h, r);
    end else if (l == 2) begin
      ds = int'(b[1][7:4]);
      a = int'(mregs[ds % NR]);
      bb = int'(mregs[int'(b[1][3:0]) % NR]);
      r = -1;
      case (h)
        0: begin r = a + bb; mc = (r > 255); end
        1: begin r = a + bb + int'(mc); mc = (r > 255); end
        2, 10: begin r = a - bb; mc = (r < 0); end
        3: begin r = a - bb - int'(mc); mc = (r < 0); end
        4: begin r = a | bb; mc = 0; end
        5: begin r = a & bb; mc = 0; end
        11: begin r = a ^ bb; mc = 0; end
        default: ;
      endcase
      if (h < 6 || h == 10 || h == 11) begin
        mz = ((r & 255) == 0);
        if (h != 10) mwrite(ds, r & 255);
      end
    end else if (l == 13) begin
      case (h)
        8: t = 1;
        6: t = mz;
        14: t = !mz;
        7: t = mc;
        15: t = !mc;
        default: t = 0;
      endcase
      if (t) mpc = {b[1], b[2]};
    end
`ifdef PROC_HALT_EN
    if (b[0] == 8'h7F) mhalt = 1;
`endif
  endtask

  task automatic load_prog(input int base);
    for (int i = 0; i < prog.size(); i++)
      mem[(base + i) & 16'hFFFF] = prog[i];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 0;
  endtask

  task automatic apply_reset();
    checking = 0;
    @(negedge clk);
    #1 reset_n = 0;
    #1;
    chk("rst_pc", {16'd0, memAddr}, 0);
    chk("rst_strobe", {31'd0, memStrobe}, 0);
    chk("rst_wren", {31'd0, regWrEn}, 0);
    chk("rst_flags", {30'd0, flags}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic start_prog(input int n,
                            input int lo,
                            input int hi);
    apply_reset();
    wlo = lo;
    whi = hi;
    model_reset();
    for (int i = 0; i < n && !mhalt; i++)
      model_step();
    wr_log.delete();
    flag_at.delete();
    hits.delete();
    cyc = 0;
    have_prev = 0;
    first_s = -1;
    first_w = -1;
    checking = 1;
    @(posedge clk);
    #2 reset_n = 1;
  endtask

  task automatic finish_prog(input int n, input bit keep);
    int budget;
    budget = n * (3 * (2 + whi) + 1) + 50;
    while (obs.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("drain_timeout", obs.size(), 0);
    if (!keep) checking = 0;
  endtask

  task automatic run_prog(input int n, input int lo, input int hi);
    start_prog(n, lo, hi);
    finish_prog(n, 0);
  endtask

  function automatic logic [1:0] fa(input int a);
    return flag_at.exists(a) ? flag_at[a] : 2'bxx;
  endfunction

  task automatic check_log(input logic [11:0] ex[$]);
    for (int i = 0; i < ex.size(); i++)
      chk("trace", (i < wr_log.size()) ? {20'd0, wr_log[i]} : 32'hx,
          {20'd0, ex[i]});
  endtask

  task automatic check_trace1();
    logic [11:0] ex[$];
    ex = '{12'h00A, 12'h114, 12'h01E, 12'h114, 12'h032};
    check_log(ex);
    chk("pc_revisit_0002",
        {31'd0, hits.exists(2) && hits[2] >= 2}, 1);
  endtask

  task automatic gen_random();
    int a, k;
    int ccs[7];
    int rrs[9];
    ccs = '{0, 6, 7, 8, 14, 15, 3};
    rrs = '{0, 1, 2, 3, 4, 5, 10, 11, 7};
    clear_mem();
    a = 0;
    while (a < 240) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1: begin
          mem[a] = {4'($urandom), 4'hC};
          mem[a+1] = 8'($urandom);
          a += 2;
        end
        2: begin
          mem[a] = {4'($urandom), 4'h8};
          mem[a+1] = 8'($urandom);
          a += 2;
        end
        3: begin
          mem[a] = {4'($urandom), 4'hE};
          a += 1;
        end
        4, 5, 9: begin
          mem[a] = {4'(rrs[$urandom_range(0, 8)]), 4'h2};
          if (k == 9) mem[a][7:4] = 4'($urandom);
          mem[a+1] = 8'($urandom);
          a += 2;
        end
        6: begin
          mem[a] = {4'(ccs[$urandom_range(0, 6)]), 4'hD};
          mem[a+1] = 8'h00;
          mem[a+2] = 8'($urandom_range(0, 240));
          a += 3;
        end
        7: begin
          mem[a] = 8'hFF;
          a += 1;
        end
        default: begin
          mem[a] = 8'($urandom);
          a += 1;
        end
      endcase
    end
  endtask

  initial begin
    int bud;
    logic [11:0] ex[$];
    reset_n = 0;
    memReady = 0;
    memDataRead = 0;
    wlo = 0;
    whi = 0;
    stale = 0;
    checking = 0;
    vec = 0;
    errs = 0;
    clear_mem();

    prog = '{8'h0C, 8'h0A, 8'h1C, 8'h14, 8'h02,
             8'h01, 8'hFF, 8'h8D, 8'h00, 8'h02};
    load_prog(0);
    run_prog(12, 0, 0);
    check_trace1();
    chk("lat_zero_wait", first_w - first_s, 4);

    run_prog(12, 3, 3);
    check_trace1();
    chk("lat_wait3", first_w - first_s, 10);

    clear_mem();
    prog = '{8'h0C, 8'hF0, 8'h1C, 8'h20, 8'h02, 8'h01,
             8'h12, 8'h01, 8'h8D, 8'h00, 8'h08};
    load_prog(0);
    run_prog(8, 0, 0);
    ex = '{12'h0F0, 12'h120, 12'h010, 12'h031};
    check_log(ex);
    chk("add_flags", {30'd0, fa(6)}, 2);
    chk("adc_flags", {30'd0, fa(8)}, 0);

    clear_mem();
    prog = '{8'h0C, 8'h05, 8'h1C, 8'h05, 8'hA2, 8'h01,
             8'h22, 8'h01, 8'h1C, 8'h01, 8'h22, 8'h01,
             8'h8D, 8'h00, 8'h0C};
    load_prog(0);
    run_prog(10, 0, 0);
    ex = '{12'h005, 12'h105, 12'h000, 12'h101, 12'h0FF};
    check_log(ex);
    chk("cp_no_write", wr_log.size(), 5);
    chk("cp_flags", {30'd0, fa(6)}, 1);
    chk("sub_zero_flags", {30'd0, fa(8)}, 1);
    chk("sub_borrow_flags", {30'd0, fa(12)}, 2);

    clear_mem();
    prog = '{8'h0C, 8'hFF, 8'h0E, 8'h6D, 8'h00, 8'h40};
    load_prog(0);
    prog = '{8'hEE, 8'h00, 8'h40, 8'h8D, 8'h00, 8'h43};
    load_prog(16'h40);
    run_prog(6, 0, 0);
    chk("jz_taken", {31'd0, hits.exists(16'h40)}, 1);
    chk("jz_no_fall", {31'd0, hits.exists(6)}, 0);
    chk("jnz_fall", {31'd0, hits.exists(16'h43)}, 1);
    chk("jnz_flags", {30'd0, fa(16'h40)}, 1);

    clear_mem();
    prog = '{8'h0C, 8'h0A, 8'h1C, 8'h14, 8'h02,
             8'h01, 8'hFF, 8'h8D, 8'h00, 8'h02};
    load_prog(0);
    start_prog(10, 3, 3);
    bud = 200;
    while (!(memStrobe && memAddr == 16'd4) && bud > 0) begin
      @(negedge clk);
      bud--;
    end
    chk("mid_wait_reached", {31'd0, bud > 0}, 1);
    checking = 0;
    apply_reset();
    stale = 1;
    run_prog(12, 0, 0);
    check_trace1();

`ifdef PROC_HALT_EN
    clear_mem();
    prog = '{8'h0C, 8'h11, 8'h7F, 8'h0C, 8'h22};
    load_prog(0);
    start_prog(5, 0, 0);
    finish_prog(5, 1);
    repeat (20) @(posedge clk);
    checking = 0;
    chk("halted_set", {31'd0, halted}, 1);
    ex = '{12'h011};
    check_log(ex);
    chk("halt_no_writes", wr_log.size(), 1);
`endif

    for (int t = 0; t < 6; t++) begin
      gen_random();
      if (t == 0) run_prog(80, 0, 0);
      else if (t == 1) run_prog(80, 2, 2);
      else run_prog(80, 0, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
